daq_capture_ctrl: RTL

Parametrised multi-channel acquisition controller that generalises the two-channel scope capture path. It has N channels and configurable sample width and buffer depth. Each channel has a pre-trigger circular buffer, single/continuous capture modes, an auto-trigger timeout, abort, and a reported trigger address. The block runs entirely in the `clk_50` domain: ADC samples arrive as per-channel `sample_valid` strobes, and the block drives one on-chip memory write port per channel.

---
 rtl/daq_capture_ctrl_if.sv | 27 ++
 rtl/daq_capture_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/daq_capture_ctrl_if.sv
// Sample-in / memory-write-out bundle for daq_capture_ctrl.
// All channel c fields sit at slice [c*W +: W] of each bus.
interface daq_capture_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 17
);
  // Strobe semantics, no backpressure: sample_valid[c] high for one clk_50
  // cycle means samples[c] is present that cycle and is consumed or dropped
  // then; mem_write[c] high for one cycle means mem_address/mem_write_data
  // for channel c must be written that cycle (they hold while mem_write is 0).
  logic [NUM_CH-1:0]        sample_valid;
  logic [NUM_CH*DATA_W-1:0] samples;
  logic [NUM_CH*DATA_W-1:0] mem_write_data;
  logic [NUM_CH*ADDR_W-1:0] mem_address;
  logic [NUM_CH-1:0]        mem_write;

  modport master (
    output sample_valid, samples,
    input  mem_write_data, mem_address, mem_write
  );

  modport slave (
    input  sample_valid, samples,
    output mem_write_data, mem_address, mem_write
  );
endinterface

// File: rtl/daq_capture_ctrl.sv
// Multi-channel pre/post-trigger capture controller: per-channel circular
// buffer writer with edge/pending/auto trigger, single or continuous capture.
module daq_capture_ctrl #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 17
) (
  input  logic                     clk_50,
  input  logic                     reset_n,
  daq_capture_ctrl_if.slave        bus,
  input  logic [NUM_CH-1:0]        trigger,
  input  logic                     arm,
  input  logic                     abort,
  input  logic [NUM_CH-1:0]        read_done,
  input  logic                     continuous,
  input  logic                     auto_en,
  input  logic [15:0]              auto_timeout,
  input  logic [ADDR_W-1:0]        pretrig,
  output logic [NUM_CH*ADDR_W-1:0] trig_addr,
  output logic [NUM_CH*3-1:0]      ch_state,
  output logic [NUM_CH-1:0]        capture_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d;
    logic [15:0]         to_cnt_q, to_cnt_d;
    logic                trig_dly_q, trig_dly_d;
    logic                trig_pend_q, trig_pend_d;
    logic [ADDR_W-1:0]   pretrig_lat_q, pretrig_lat_d;
    logic                cont_lat_q, cont_lat_d;
    logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;

    logic                vld;
    logic [DATA_W-1:0]   smp;
    logic                trig_edge;
    logic                auto_hit;
    logic                trig_cond;
    logic [ADDR_W-1:0]   post_len;
    logic                do_wr;
    logic                go_pre;

    assign vld       = bus.sample_valid[c];
    assign smp       = bus.samples[c*DATA_W +: DATA_W];
    assign trig_edge = trigger[c] & ~trig_dly_q;
    assign auto_hit  = auto_en && (auto_timeout != 16'd0) && (to_cnt_q >= auto_timeout);
    assign trig_cond = trig_edge | trig_pend_q | auto_hit;
    // Samples still to take after the trigger sample so the buffer ends full.
    assign post_len  = {ADDR_W{1'b1}} - pretrig_lat_q;

    always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      pre_cnt_d     = pre_cnt_q;
      post_cnt_d    = post_cnt_q;
      to_cnt_d      = to_cnt_q;
      trig_dly_d    = trigger[c];
      trig_pend_d   = trig_pend_q;
      pretrig_lat_d = pretrig_lat_q;
      cont_lat_d    = cont_lat_q;
      trig_addr_d   = trig_addr_q;
      mem_we_d      = 1'b0;
      mem_addr_d    = mem_addr_q;
      mem_data_d    = mem_data_q;
      do_wr         = 1'b0;
      go_pre        = 1'b0;

      if (abort) begin
        state_d = S_IDLE;
      end else if (arm && (state_q == S_IDLE || state_q == S_DONE)) begin
        go_pre = 1'b1;
      end else begin
        case (state_q)
          S_PRE: begin
            if (vld) begin
              do_wr     = 1'b1;
              pre_cnt_d = pre_cnt_q + 1'b1;
            end
            if (pretrig_lat_q == '0 || (vld && (pre_cnt_q + 1'b1) == pretrig_lat_q))
              state_d = S_ARMED;
          end
          S_ARMED: begin
            if (to_cnt_q != 16'hffff) to_cnt_d = to_cnt_q + 16'd1;
            if (vld) begin
              do_wr = 1'b1;
              if (trig_cond) begin
                trig_addr_d = wr_ptr_q;
                post_cnt_d  = post_len;
                state_d     = (post_len == '0) ? S_DONE : S_POST;
              end
            end else if (trig_edge) begin
              trig_pend_d = 1'b1;
            end
          end
          S_POST: begin
            if (vld) begin
              do_wr      = 1'b1;
              post_cnt_d = post_cnt_q - 1'b1;
              if (post_cnt_q == {{(ADDR_W-1){1'b0}}, 1'b1}) state_d = S_DONE;
            end
          end
          S_DONE: begin
            if (read_done[c]) begin
              if (cont_lat_q) go_pre = 1'b1;
              else            state_d = S_IDLE;
            end
          end
          default: ;
        endcase
      end

      // Every path into PRE is an arm event: restart the buffer and relatch config.
      if (go_pre) begin
        state_d       = S_PRE;
        wr_ptr_d      = '0;
        pre_cnt_d     = '0;
        to_cnt_d      = '0;
        trig_pend_d   = 1'b0;
        pretrig_lat_d = pretrig;
        cont_lat_d    = continuous;
      end

      if (do_wr) begin
        mem_we_d   = 1'b1;
        mem_addr_d = wr_ptr_q;
        mem_data_d = smp;
        wr_ptr_d   = wr_ptr_q + 1'b1;
      end
    end

    always_ff @(posedge clk_50) begin
      if (!reset_n) begin
        state_q       <= S_IDLE;
        wr_ptr_q      <= '0;
        pre_cnt_q     <= '0;
        post_cnt_q    <= '0;
        to_cnt_q      <= '0;
        trig_dly_q    <= 1'b0;
        trig_pend_q   <= 1'b0;
        pretrig_lat_q <= '0;
        cont_lat_q    <= 1'b0;
        trig_addr_q   <= '0;
        mem_we_q      <= 1'b0;
        mem_addr_q    <= '0;
        mem_data_q    <= '0;
      end else begin
        state_q       <= state_d;
        wr_ptr_q      <= wr_ptr_d;
        pre_cnt_q     <= pre_cnt_d;
        post_cnt_q    <= post_cnt_d;
        to_cnt_q      <= to_cnt_d;
        trig_dly_q    <= trig_dly_d;
        trig_pend_q   <= trig_pend_d;
        pretrig_lat_q <= pretrig_lat_d;
        cont_lat_q    <= cont_lat_d;
        trig_addr_q   <= trig_addr_d;
        mem_we_q      <= mem_we_d;
        mem_addr_q    <= mem_addr_d;
        mem_data_q    <= mem_data_d;
      end
    end

    assign bus.mem_write[c]                        = mem_we_q;
    assign bus.mem_address[c*ADDR_W +: ADDR_W]     = mem_addr_q;
    assign bus.mem_write_data[c*DATA_W +: DATA_W]  = mem_data_q;
    assign trig_addr[c*ADDR_W +: ADDR_W]           = trig_addr_q;
    assign ch_state[c*3 +: 3]                      = state_q;
    assign capture_done[c]                         = (state_q == S_DONE);
  end

endmodule
